// File: rtl/div.sv
// div: multi-cycle radix-2 restoring integer divider for DIV/DIVU.
//
// The execute stage holds start_i high with the operands and stalls until
// ready_o rises.
//
// Operand handling
//   - Operands are latched on the accepting edge and never looked at again.
//   - Signed operands are reduced to unsigned magnitudes.
//   - The recorded signs are applied to the quotient and remainder once the
//     DATA_WIDTH iterations have finished.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   signed_div_i 1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      level request, held until ready_o is seen
//   annul_i      discard the current or pending division
//   result_o     {remainder, quotient}; valid while ready_o is high
//   ready_o      result available
module div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [DATA_WIDTH-1:0]     opdata1_i,
  input  logic [DATA_WIDTH-1:0]     opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [2*DATA_WIDTH-1:0]   result_o,
  output logic                      ready_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [DATA_WIDTH-1:0]   rem, rem_next;
  logic [DATA_WIDTH-1:0]   quo, quo_next;
  logic [DATA_WIDTH-1:0]   dsor, dsor_next;
  logic                    neg_quo, neg_quo_next;
  logic                    neg_rem, neg_rem_next;
  logic [2*DATA_WIDTH-1:0] result_next;
  logic                    ready_next;

  logic [DATA_WIDTH-1:0]   mag1, mag2;
  logic [DATA_WIDTH:0]     shifted;
  logic                    fits;
  logic [DATA_WIDTH-1:0]   diff;
  logic [DATA_WIDTH-1:0]   quo_final, rem_final;

  // Two's-complement magnitudes of the operands, used only on the accepting edge.
  assign mag1 = (signed_div_i && opdata1_i[DATA_WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[DATA_WIDTH-1]) ? -opdata2_i : opdata2_i;

  // One restoring step.
  //   - The quotient register starts out holding the dividend, so its MSB is
  //     the next dividend bit to shift into the partial remainder.
  //   - The W+1-bit partial remainder is compared against the divisor.
  //   - When the subtraction succeeds, the true difference is below the divisor
  //     and therefore fits in W bits, so the low-W-bit subtraction is exact.
  assign shifted = {rem, quo[DATA_WIDTH-1]};
  assign fits    = shifted >= {1'b0, dsor};
  assign diff    = shifted[DATA_WIDTH-1:0] - dsor;

  // Sign correction: the quotient takes the XOR of the operand signs, and the
  // remainder follows the dividend.
  assign quo_final = neg_quo ? -quo : quo;
  assign rem_final = neg_rem ? -rem : rem;

  // State register. Reset wins over everything, so nothing partial can leak out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dsor     <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      rem      <= rem_next;
      quo      <= quo_next;
      dsor     <= dsor_next;
      neg_quo  <= neg_quo_next;
      neg_rem  <= neg_rem_next;
      result_o <= result_next;
      ready_o  <= ready_next;
    end
  end

  // Next-state logic.
  //   - Every register holds its value unless a state below changes it.
  //   - Annul takes priority over iteration progress while a division is running.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    rem_next     = rem;
    quo_next     = quo;
    dsor_next    = dsor;
    neg_quo_next = neg_quo;
    neg_rem_next = neg_rem;
    result_next  = result_o;
    ready_next   = ready_o;

    case (state)
      DIV_FREE: begin
        ready_next  = 1'b0;
        result_next = '0;
        if (start_i && !annul_i) begin
          rem_next     = '0;
          quo_next     = mag1;
          dsor_next    = mag2;
          neg_quo_next = signed_div_i && (opdata1_i[DATA_WIDTH-1] ^ opdata2_i[DATA_WIDTH-1]);
          neg_rem_next = signed_div_i && opdata1_i[DATA_WIDTH-1];
          cnt_next     = '0;
          state_next   = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end

      DIV_BY_ZERO: begin
        result_next = '0;
        if (annul_i) begin
          ready_next = 1'b0;
          cnt_next   = '0;
          state_next = DIV_FREE;
        end else begin
          ready_next = 1'b1;
          state_next = DIV_END;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          ready_next  = 1'b0;
          result_next = '0;
          cnt_next    = '0;
          state_next  = DIV_FREE;
        end else if (cnt == CNT_W'(DATA_WIDTH)) begin
          result_next = {rem_final, quo_final};
          ready_next  = 1'b1;
          state_next  = DIV_END;
        end else begin
          rem_next = fits ? diff : shifted[DATA_WIDTH-1:0];
          quo_next = {quo[DATA_WIDTH-2:0], fits};
          cnt_next = cnt + CNT_W'(1);
        end
      end

      DIV_END: begin
        // Annul is ignored here; the requester withdraws by dropping start_i.
        if (!start_i) begin
          ready_next  = 1'b0;
          result_next = '0;
          state_next  = DIV_FREE;
        end
      end

      default: begin
        state_next = DIV_FREE;
      end
    endcase
  end

endmodule

// File: tb/tb_div.sv
// tb_div: randomized and directed bench for the div block.
//
// Expected behaviour comes from a reference model written with plain 64-bit
// integer arithmetic. A per-cycle compare process checks ready_o and result_o
// against the expected timeline that the driver maintains.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int          vectors;
  int          miscompares;
  bit          check_en;
  bit          exp_ready;
  logic [63:0] exp_result;

  div #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model.
  //   - 64-bit signed arithmetic truncates toward zero, and the remainder
  //     follows the dividend, which matches MIPS DIV/DIVU.
  //   - The -2^31 / -1 case does not overflow in 64 bits; its low 32 bits give
  //     the expected wrapped quotient.
  //   - Division by zero yields zero.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Single named comparison used by the directed checks.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Per-cycle compare of the DUT outputs against the expected timeline,
  // sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        vectors++;
        if (ready_o !== exp_ready || result_o !== exp_result) begin
          miscompares++;
          $display("[TB] FAIL cycle t=%0t: ready %b result %h, expected ready %b result %h",
                   $time, ready_o, result_o, exp_ready, exp_result);
        end
      end
    end
  end

  // Run one transaction and keep the expected timeline up to date.
  //   pre_annul   edges during which start is held with annul set (no acceptance)
  //   abort_edge  edge index after E0 at which annul/reset cancels (0 = none)
  //   use_reset   cancel with rst instead of annul
  //   early_drop  drop start mid-division without annul
  //   hold        extra edges start stays high in DivEnd (annul toggled randomly)
  // Outputs are sampled 1 unit after the edge on which the result (or the
  // abort) takes effect.
  task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                               input int pre_annul, input int abort_edge, input bit use_reset,
                               input bit early_drop, input int hold,
                               output logic [63:0] got_res, output logic got_rdy);
    int lat;
    bit aborted;
    lat     = (b == 32'd0) ? 1 : 33;
    aborted = 1'b0;
    got_res = 'x;
    got_rdy = 1'bx;
    @(negedge clk);
    rst          = 1'b0;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = (pre_annul > 0);
    for (int p = 0; p < pre_annul; p++) begin
      @(posedge clk);
      @(negedge clk);
    end
    annul_i = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom);
      if (early_drop && k == 5) start_i = 1'b0;
      if (k == abort_edge) begin
        if (use_reset) rst = 1'b1;
        else           annul_i = 1'b1;
        start_i = 1'b0;
      end
      @(posedge clk);
      if (k == abort_edge) begin
        exp_ready  = 1'b0;
        exp_result = 64'd0;
        aborted    = 1'b1;
        break;
      end
      if (k == lat) begin
        exp_ready  = 1'b1;
        exp_result = model(sgn, a, b);
      end
    end
    #1;
    got_res = result_o;
    got_rdy = ready_o;
    if (!aborted) begin
      if (!early_drop) begin
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          annul_i = 1'($urandom);
          @(posedge clk);
        end
      end
      @(negedge clk);
      start_i = 1'b0;
      annul_i = 1'b0;
      @(posedge clk);
      exp_ready  = 1'b0;
      exp_result = 64'd0;
    end
  endtask

  // Main sequence: reset, model pins, directed cases, then randomized traffic.
  initial begin
    logic [63:0] res;
    logic        rdy;
    logic [31:0] ra, rb;
    bit          rs;
    int          ab;

    vectors      = 0;
    miscompares  = 0;
    check_en     = 1'b0;
    exp_ready    = 1'b0;
    exp_result   = 64'd0;
    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;

    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    check_en = 1'b1;

    checkOutput("model_100_7",   model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    checkOutput("model_m7_2",    model(1'b1, 32'hFFFFFFF9, 32'd2), {32'hFFFFFFFF, 32'hFFFFFFFD});
    checkOutput("model_ovf",     model(1'b1, 32'h80000000, 32'hFFFFFFFF), {32'd0, 32'h80000000});
    checkOutput("model_ovf_u",   model(1'b0, 32'h80000000, 32'hFFFFFFFF), {32'h80000000, 32'd0});

    applyStimulus(1'b0, 32'd100, 32'd7, 0, 0, 1'b0, 1'b0, 4, res, rdy);
    checkOutput("udiv_100_7", res, {32'd2, 32'd14});
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 0, 0, 1'b0, 1'b0, 1, res, rdy);
    checkOutput("sdiv_m7_2", res, {32'hFFFFFFFF, 32'hFFFFFFFD});
    applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, 0, 0, 1'b0, 1'b0, 0, res, rdy);
    checkOutput("sdiv_7_m2", res, {32'h00000001, 32'hFFFFFFFD});
    applyStimulus(1'b0, 32'd5, 32'd0, 0, 0, 1'b0, 1'b0, 2, res, rdy);
    checkOutput("udiv_by_zero_rdy", {63'd0, rdy}, 64'd1);
    checkOutput("udiv_by_zero_res", res, 64'd0);
    applyStimulus(1'b1, 32'd5, 32'd0, 0, 0, 1'b0, 1'b0, 0, res, rdy);
    checkOutput("sdiv_by_zero_rdy", {63'd0, rdy}, 64'd1);
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, 1, res, rdy);
    checkOutput("sdiv_overflow", res, {32'd0, 32'h80000000});
    applyStimulus(1'b0, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, 1, res, rdy);
    checkOutput("udiv_overflow_ops", res, {32'h80000000, 32'd0});

    // Annul once cnt has reached 10, then a normal 9 / 3.
    applyStimulus(1'b0, 32'd1000, 32'd3, 0, 11, 1'b0, 1'b0, 0, res, rdy);
    checkOutput("annul_ready", {63'd0, rdy}, 64'd0);
    checkOutput("annul_result", res, 64'd0);
    applyStimulus(1'b0, 32'd9, 32'd3, 0, 0, 1'b0, 1'b0, 0, res, rdy);
    checkOutput("after_annul_9_3", res, {32'd0, 32'd3});

    // Annul while in DivByZero, annul blocking acceptance, and a start dropped mid-division.
    applyStimulus(1'b1, 32'd5, 32'd0, 0, 1, 1'b0, 1'b0, 0, res, rdy);
    checkOutput("annul_dbz_ready", {63'd0, rdy}, 64'd0);
    applyStimulus(1'b0, 32'd77, 32'd10, 3, 0, 1'b0, 1'b0, 0, res, rdy);
    checkOutput("annul_blocks_free", res, {32'd7, 32'd7});
    applyStimulus(1'b0, 32'd50, 32'd5, 0, 0, 1'b0, 1'b1, 0, res, rdy);
    checkOutput("early_drop_50_5", res, {32'd0, 32'd10});

    // Reset mid-division, then a start right as reset deasserts.
    applyStimulus(1'b1, 32'hFFFF0000, 32'd12345, 0, 20, 1'b1, 1'b0, 0, res, rdy);
    checkOutput("reset_mid_ready", {63'd0, rdy}, 64'd0);
    checkOutput("reset_mid_result", res, 64'd0);
    applyStimulus(1'b0, 32'd100, 32'd7, 0, 0, 1'b0, 1'b0, 0, res, rdy);
    checkOutput("after_reset_100_7", res, {32'd2, 32'd14});

    // Randomized traffic, including corner operands and random aborts.
    for (int n = 0; n < 30; n++) begin
      rs = 1'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      ab = 0;
      if ($urandom_range(0, 5) == 0) ab = (rb == 32'd0) ? 1 : $urandom_range(1, 33);
      applyStimulus(rs, ra, rb, $urandom_range(0, 1), ab, 1'($urandom),
                    (ab == 0 && rb != 32'd0 && $urandom_range(0, 4) == 0),
                    $urandom_range(0, 3), res, rdy);
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
